// File: rtl/wdg_rst_ctrl.sv
// Watchdog reset controller.
// Stage 1 raises a level interrupt on each new rising edge of the stage-1
// timeout and holds it until acknowledged. Stage 2 runs a small FSM: wait
// RST_DELAY_CYCLES, drive a RST_PULSE_CYCLES-wide active-low system reset,
// then park until the stage-2 level drops. Each issued reset is recorded in
// a sticky cause flag and a saturating 4-bit counter.
module wdg_rst_ctrl #(
  parameter int unsigned RST_DELAY_CYCLES = 8,   // 0..255
  parameter int unsigned RST_PULSE_CYCLES = 16   // 1..255
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       i_irq1,
  input  logic       i_irq2,
  input  logic       i_irq_ack,
  input  logic       i_cause_clr,
  output logic       o_irq,
  output logic       o_sys_rst_n,
  output logic       o_rst_cause,
  output logic [3:0] o_rst_cnt,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ASSERT = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Counter reload values; the delay load is unused when the delay is zero.
  localparam logic [7:0] DELAY_LOAD =
    (RST_DELAY_CYCLES > 0) ? 8'(RST_DELAY_CYCLES - 1) : 8'd0;
  localparam logic [7:0] PULSE_LOAD = 8'(RST_PULSE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       irq1_q, irq2_q;
  logic       irq1_rise, irq2_rise;
  logic       assert_entry;
  logic [3:0] rst_cnt_base;

  assign irq1_rise = i_irq1 & ~irq1_q;
  assign irq2_rise = i_irq2 & ~irq2_q;

  // Single-stage history of both timeout levels for rising-edge detection.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of block order.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      irq1_q <= 1'b0;
      irq2_q <= 1'b0;
    end else begin
      irq1_q <= i_irq1;
      irq2_q <= i_irq2;
    end
  end

  // Stage-1 pending flag: a new edge wins over a coincident acknowledge.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      o_irq <= 1'b0;
    end else if (irq1_rise) begin
      o_irq <= 1'b1;
    end else if (i_irq_ack) begin
      o_irq <= 1'b0;
    end
  end

  // FSM state and shared down-counter registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic; stage-2 edges are only honoured in IDLE.
  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    assert_entry = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (irq2_rise) begin
          if (RST_DELAY_CYCLES == 0) begin
            state_d      = ASSERT;
            cnt_d        = PULSE_LOAD;
            assert_entry = 1'b1;
          end else begin
            state_d = DELAY;
            cnt_d   = DELAY_LOAD;
          end
        end
      end
      DELAY: begin
        if (cnt_q == 8'd0) begin
          state_d      = ASSERT;
          cnt_d        = PULSE_LOAD;
          assert_entry = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ASSERT: begin
        if (cnt_q == 8'd0) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        // Leave only once the stage-2 level has dropped, so a stuck level
        // cannot fire a second reset.
        if (!irq2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A clear coincident with a new reset is applied first, so the
  // increment lands on zero and the event is not lost.
  always_comb begin
    rst_cnt_base = i_cause_clr ? 4'd0 : o_rst_cnt;
  end

  // Reset-cause flag and saturating reset counter.
  // NOTE: these history registers get the asynchronous reset too; a power-on
  // reset must start from a known "no watchdog reset yet" record.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      o_rst_cause <= 1'b0;
      o_rst_cnt   <= 4'd0;
    end else if (assert_entry) begin
      o_rst_cause <= 1'b1;
      o_rst_cnt   <= (rst_cnt_base == 4'hF) ? 4'hF : rst_cnt_base + 4'd1;
    end else if (i_cause_clr) begin
      o_rst_cause <= 1'b0;
      o_rst_cnt   <= 4'd0;
    end
  end

  // Outputs decoded from the state register only; no input reaches them
  // combinationally, and reset forces IDLE so the system reset releases
  // asynchronously.
  assign o_sys_rst_n = (state_q != ASSERT);
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_wdg_rst_ctrl.sv
// Self-checking bench for wdg_rst_ctrl: a stage-1 vector table, directed
// stage-2 sequences on a default and a zero-delay/one-clock instance, and a
// randomized run against an elapsed-time reference model.
module tb_wdg_rst_ctrl;

  localparam int D = 8;
  localparam int P = 16;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       irq1 = 1'b0, irq2 = 1'b0, ack = 1'b0, clr = 1'b0;
  logic       o_irq, o_sys_rst_n, o_rst_cause, o_busy;
  logic [3:0] o_rst_cnt;

  logic       t2_irq2 = 1'b0;
  logic       z0 = 1'b0;
  logic       t2_irq, t2_sys_rst_n, t2_rst_cause, t2_busy;
  logic [3:0] t2_rst_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wdg_rst_ctrl #(.RST_DELAY_CYCLES(D), .RST_PULSE_CYCLES(P)) dut (
    .clk(clk), .res_n(res_n),
    .i_irq1(irq1), .i_irq2(irq2), .i_irq_ack(ack), .i_cause_clr(clr),
    .o_irq(o_irq), .o_sys_rst_n(o_sys_rst_n), .o_rst_cause(o_rst_cause),
    .o_rst_cnt(o_rst_cnt), .o_busy(o_busy)
  );

  wdg_rst_ctrl #(.RST_DELAY_CYCLES(0), .RST_PULSE_CYCLES(1)) dut2 (
    .clk(clk), .res_n(res_n),
    .i_irq1(z0), .i_irq2(t2_irq2), .i_irq_ack(z0), .i_cause_clr(z0),
    .o_irq(t2_irq), .o_sys_rst_n(t2_sys_rst_n), .o_rst_cause(t2_rst_cause),
    .o_rst_cnt(t2_rst_cnt), .o_busy(t2_busy)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res_n = 1'b0; irq1 = 0; irq2 = 0; ack = 0; clr = 0; t2_irq2 = 0;
    #23;
    @(posedge clk);
    #1 res_n = 1'b1;
  endtask

  // Reference model: tracks elapsed cycles since the trigger instead of
  // FSM states. k counts cycles since the sequence became busy.
  bit m_active, m_prev1, m_prev2, m_pend, m_cause;
  int m_k, m_cnt;

  function automatic void model_reset();
    m_active = 0; m_prev1 = 0; m_prev2 = 0; m_pend = 0; m_cause = 0;
    m_k = 0; m_cnt = 0;
  endfunction

  // Apply one clock edge to the model with the inputs present at that edge.
  function automatic void model_step(bit in1, bit in2, bit a, bit c);
    bit entry = 0;
    if (!m_active) begin
      if (in2 && !m_prev2) begin
        m_active = 1; m_k = 0;
        entry = (D == 0);
      end
    end else if (m_k >= D + P) begin
      if (!m_prev2) m_active = 0;
    end else begin
      m_k++;
      entry = (m_k == D);
    end
    if (entry) begin
      m_cnt   = ((c ? 0 : m_cnt) + 1 > 15) ? 15 : (c ? 0 : m_cnt) + 1;
      m_cause = 1;
    end else if (c) begin
      m_cnt = 0; m_cause = 0;
    end
    if (in1 && !m_prev1) m_pend = 1;
    else if (a)          m_pend = 0;
    m_prev1 = in1;
    m_prev2 = in2;
  endfunction

  function automatic logic [7:0] model_outs();
    bit rst_low = m_active && (m_k >= D) && (m_k < D + P);
    return {m_pend, ~rst_low, m_active, m_cause, m_cnt[3:0]};
  endfunction

  typedef struct {
    logic in1;
    logic a;
    logic exp_irq;
  } vec_t;

  vec_t vecs[11];

  // Run one stage-2 sequence to completion, dropping the level early.
  task automatic run_seq();
    irq2 = 1; tick();
    irq2 = 0;
    for (int t = 0; t < 40 && o_busy; t++) tick();
  endtask

  initial begin
    int first, lows, busy1;
    logic [7:0] exp_o;

    // ---------------- reset state ----------------
    do_reset();
    check("reset_irq",   o_irq, 0);
    check("reset_rst_n", o_sys_rst_n, 1);
    check("reset_busy",  o_busy, 0);
    check("reset_cause", o_rst_cause, 0);
    check("reset_cnt",   o_rst_cnt, 0);

    // ---------------- stage-1 vector table ----------------
    vecs[0]  = '{1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1};  // rising edge sets pending
    vecs[2]  = '{1'b0, 1'b0, 1'b1};  // held without ack
    vecs[3]  = '{1'b0, 1'b1, 1'b0};  // ack clears
    vecs[4]  = '{1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b0};  // ack while level steady high
    vecs[6]  = '{1'b1, 1'b0, 1'b0};  // steady high does not re-set
    vecs[7]  = '{1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1};  // ack coincident with new edge
    vecs[9]  = '{1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0};
    foreach (vecs[i]) begin
      irq1 = vecs[i].in1; ack = vecs[i].a;
      tick();
      check($sformatf("vec%0d_irq", i), o_irq, vecs[i].exp_irq);
      check($sformatf("vec%0d_busy", i), o_busy, 0);
    end
    irq1 = 0; ack = 0;

    // ---------------- default stage-2 timing ----------------
    do_reset();
    for (int i = 0; i < 9; i++) tick();
    irq2 = 1;
    first = -1; lows = 0; busy1 = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (t == 1) busy1 = o_busy;
      if (!o_sys_rst_n) begin
        lows++;
        if (first < 0) first = t;
      end
    end
    check("s2_busy_next",   busy1, 1);
    check("s2_first_low",   first, D + 1);
    check("s2_low_width",   lows, P);
    check("s2_cnt",         o_rst_cnt, 1);
    check("s2_cause",       o_rst_cause, 1);
    check("s2_hold_stuck",  o_busy, 1);
    irq2 = 0;
    tick(); tick();
    check("s2_back_idle",   o_busy, 0);

    // ---------------- zero delay, one-clock pulse ----------------
    t2_irq2 = 1;
    first = -1; lows = 0;
    for (int t = 1; t <= 5; t++) begin
      tick();
      if (!t2_sys_rst_n) begin
        lows++;
        if (first < 0) first = t;
      end
    end
    t2_irq2 = 0;
    check("z_first_low", first, 1);
    check("z_low_width", lows, 1);
    check("z_cnt",       t2_rst_cnt, 1);

    // ---------------- saturation, coincident clear, stuck level ----------------
    do_reset();
    for (int s = 0; s < 17; s++) run_seq();
    check("sat_cnt",   o_rst_cnt, 15);
    check("sat_cause", o_rst_cause, 1);
    irq2 = 1; tick(); irq2 = 0;
    for (int i = 0; i < D - 1; i++) tick();
    clr = 1; tick(); clr = 0;   // this edge is the ASSERT entry
    check("clr_coinc_rst",   o_sys_rst_n, 0);
    check("clr_coinc_cnt",   o_rst_cnt, 1);
    check("clr_coinc_cause", o_rst_cause, 1);
    for (int t = 0; t < 40 && o_busy; t++) tick();
    clr = 1; tick(); clr = 0;
    check("clr_cnt",   o_rst_cnt, 0);
    check("clr_cause", o_rst_cause, 0);
    irq2 = 1;
    lows = 0;
    for (int t = 0; t < 80; t++) begin
      tick();
      if (!o_sys_rst_n) lows++;
    end
    check("stuck_one_pulse", lows, P);
    check("stuck_parked",    o_busy, 1);
    check("stuck_cnt",       o_rst_cnt, 1);
    irq2 = 0; tick(); tick();

    // ---------------- reset during ASSERT; level high across release ----------------
    irq2 = 1; tick(); irq2 = 0;
    for (int i = 0; i < D + 2; i++) tick();
    check("mid_in_assert", o_sys_rst_n, 0);
    irq2 = 1;
    #2 res_n = 1'b0;
    #1;
    check("mid_rst_n", o_sys_rst_n, 1);
    check("mid_busy",  o_busy, 0);
    check("mid_cnt",   o_rst_cnt, 0);
    check("mid_cause", o_rst_cause, 0);
    check("mid_irq",   o_irq, 0);
    @(posedge clk);
    #1 res_n = 1'b1;
    tick();
    check("release_edge_busy", o_busy, 1);

    // ---------------- randomized run against the model ----------------
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0)  irq1 = ~irq1;
      if ($urandom_range(0, 24) == 0) irq2 = ~irq2;
      ack = ($urandom_range(0, 5) == 0);
      clr = ($urandom_range(0, 40) == 0);
      model_step(irq1, irq2, ack, clr);
      tick();
      exp_o = model_outs();
      check($sformatf("rand%0d_{irq,rstn,busy,cause,cnt}", c),
            int'({o_irq, o_sys_rst_n, o_busy, o_rst_cause, o_rst_cnt}), int'(exp_o));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
